// File: rtl/cache_types.sv
// Shared cache-side types for the LLC and its memory bridge.
//   llc_mem_req_t : line-granular request (hwrite, hprot, line address, full line)
//   llc_mem_rsp_t : reassembled read line returned to the LLC
//   line_t        : packed array of words, index 0 is the lowest word / first beat
package cache_types;

    localparam int WORDS_PER_LINE = 4;
    localparam int WORD_BITS      = 64;
    localparam int LINE_ADDR_BITS = 27;
    localparam int OFFSET_BITS    = 5;
    localparam int BEAT_CNT_BITS  = $clog2(WORDS_PER_LINE);

    typedef logic [WORD_BITS-1:0]                      word_t;
    typedef logic [WORDS_PER_LINE-1:0][WORD_BITS-1:0]  line_t;
    typedef logic [1:0]                                hprot_t;
    typedef logic [LINE_ADDR_BITS-1:0]                 line_addr_t;
    typedef logic [BEAT_CNT_BITS-1:0]                  beat_cnt_t;

    typedef struct packed {
        logic       hwrite;
        hprot_t     hprot;
        line_addr_t addr;
        line_t      line;
    } llc_mem_req_t;

    typedef struct packed {
        line_t line;
    } llc_mem_rsp_t;

endpackage

// File: rtl/line_beat_counter.sv
// Beat index within a line burst, shared by the write and read data paths.
//   clk, rst   : clock, synchronous active-low reset
//   clear_i    : restart the burst at beat 0 (priority over incr_i)
//   incr_i     : advance one beat; wraps modulo WORDS_PER_LINE
//   cnt_o      : current beat index
//   is_last_o  : current beat is the final one of a full line
module line_beat_counter
    import cache_types::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      clear_i,
    input  logic      incr_i,
    output beat_cnt_t cnt_o,
    output logic      is_last_o
);

    beat_cnt_t cnt_q;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of its neighbours, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (incr_i) begin
            // WORDS_PER_LINE is a power of two, so natural overflow is the wrap.
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o     = cnt_q;
    assign is_last_o = (cnt_q == beat_cnt_t'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/llc_mem_bridge.sv
// Bridge between the LLC line-granular request/response channels and the
// memory controller's command + word-beat bus. One transaction at a time.
//   clk, rst                      : clock, synchronous active-low reset
//   llc_mem_req_valid/ready/_i    : line request from the LLC
//   llc_mem_rsp_valid/ready, rsp  : reassembled read line back to the LLC
//   mem_cmd_*                     : command (write flag, byte address, hprot)
//   mem_wdata_*                   : write beats, lowest word first
//   mem_rdata_*                   : read beats, lowest word first
//   proto_err                     : sticky read-burst length mismatch flag
module llc_mem_bridge
    import cache_types::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  llc_mem_req_valid,
    output logic                                  llc_mem_req_ready,
    input  llc_mem_req_t                          llc_mem_req_i,
    output logic                                  llc_mem_rsp_valid,
    input  logic                                  llc_mem_rsp_ready,
    output llc_mem_rsp_t                          llc_mem_rsp,
    output logic                                  mem_cmd_valid,
    input  logic                                  mem_cmd_ready,
    output logic                                  mem_cmd_write,
    output logic [LINE_ADDR_BITS+OFFSET_BITS-1:0] mem_cmd_addr,
    output hprot_t                                mem_cmd_hprot,
    output logic                                  mem_wdata_valid,
    input  logic                                  mem_wdata_ready,
    output word_t                                 mem_wdata,
    output logic                                  mem_wdata_last,
    input  logic                                  mem_rdata_valid,
    output logic                                  mem_rdata_ready,
    input  word_t                                 mem_rdata,
    input  logic                                  mem_rdata_last,
    output logic                                  proto_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_RSP
    } state_e;

    state_e       state_q, state_d;
    llc_mem_req_t req_q;
    line_t        rsp_line_q;
    logic         proto_err_q;

    beat_cnt_t    beat_cnt;
    logic         beat_last;

    logic req_hs, cmd_hs, wr_hs, rd_hs, rsp_hs, rd_done;

    // All handshake outputs decode from state only; no input-to-output paths.
    assign llc_mem_req_ready = (state_q == ST_IDLE);
    assign mem_cmd_valid     = (state_q == ST_CMD);
    assign mem_wdata_valid   = (state_q == ST_WDATA);
    assign mem_rdata_ready   = (state_q == ST_RDATA);
    assign llc_mem_rsp_valid = (state_q == ST_RSP);

    assign req_hs = llc_mem_req_valid & llc_mem_req_ready;
    assign cmd_hs = mem_cmd_valid     & mem_cmd_ready;
    assign wr_hs  = mem_wdata_valid   & mem_wdata_ready;
    assign rd_hs  = mem_rdata_valid   & mem_rdata_ready;
    assign rsp_hs = llc_mem_rsp_valid & llc_mem_rsp_ready;

    // A read burst ends on the first of: explicit last, or a full line of beats.
    assign rd_done = rd_hs & (mem_rdata_last | beat_last);

    // The counter is cleared as the FSM enters CMD, so it is 0 at the first beat.
    line_beat_counter u_beat_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (req_hs),
        .incr_i    (wr_hs | rd_hs),
        .cnt_o     (beat_cnt),
        .is_last_o (beat_last)
    );

    // NOTE: next-state is given a default before the case so no path through
    // this block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (req_hs)  state_d = ST_CMD;
            ST_CMD:   if (cmd_hs)  state_d = req_q.hwrite ? ST_WDATA : ST_RDATA;
            ST_WDATA: if (wr_hs && beat_last) state_d = ST_IDLE;
            ST_RDATA: if (rd_done) state_d = ST_RSP;
            ST_RSP:   if (rsp_hs)  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: the response line is wide, but it is reset on purpose: slots not
    // written by a short burst expose their old contents, which must be a
    // defined value after reset rather than X.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            rsp_line_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_hs) begin
                req_q <= llc_mem_req_i;
            end
            if (rd_hs) begin
                rsp_line_q[beat_cnt] <= mem_rdata;
                // Early last (last before the final slot) or missing last
                // (no last on the final slot) are both length mismatches.
                if (mem_rdata_last != beat_last) begin
                    proto_err_q <= 1'b1;
                end
            end
        end
    end

    assign mem_cmd_write    = req_q.hwrite;
    assign mem_cmd_addr     = {req_q.addr, {OFFSET_BITS{1'b0}}};
    assign mem_cmd_hprot    = req_q.hprot;
    assign mem_wdata        = req_q.line[beat_cnt];
    assign mem_wdata_last   = beat_last;
    assign llc_mem_rsp.line = rsp_line_q;
    assign proto_err        = proto_err_q;

endmodule

// File: tb/tb_llc_mem_bridge.sv
// Self-checking bench for llc_mem_bridge: directed scenarios followed by
// randomized read/write transactions, checked against a line-level model.
module tb_llc_mem_bridge;
    import cache_types::*;

    logic                                  clk = 1'b0;
    logic                                  rst;
    logic                                  llc_mem_req_valid;
    logic                                  llc_mem_req_ready;
    llc_mem_req_t                          llc_mem_req_i;
    logic                                  llc_mem_rsp_valid;
    logic                                  llc_mem_rsp_ready;
    llc_mem_rsp_t                          llc_mem_rsp;
    logic                                  mem_cmd_valid;
    logic                                  mem_cmd_ready;
    logic                                  mem_cmd_write;
    logic [LINE_ADDR_BITS+OFFSET_BITS-1:0] mem_cmd_addr;
    hprot_t                                mem_cmd_hprot;
    logic                                  mem_wdata_valid;
    logic                                  mem_wdata_ready;
    word_t                                 mem_wdata;
    logic                                  mem_wdata_last;
    logic                                  mem_rdata_valid;
    logic                                  mem_rdata_ready;
    word_t                                 mem_rdata;
    logic                                  mem_rdata_last;
    logic                                  proto_err;

    llc_mem_bridge dut (
        .clk               (clk),
        .rst               (rst),
        .llc_mem_req_valid (llc_mem_req_valid),
        .llc_mem_req_ready (llc_mem_req_ready),
        .llc_mem_req_i     (llc_mem_req_i),
        .llc_mem_rsp_valid (llc_mem_rsp_valid),
        .llc_mem_rsp_ready (llc_mem_rsp_ready),
        .llc_mem_rsp       (llc_mem_rsp),
        .mem_cmd_valid     (mem_cmd_valid),
        .mem_cmd_ready     (mem_cmd_ready),
        .mem_cmd_write     (mem_cmd_write),
        .mem_cmd_addr      (mem_cmd_addr),
        .mem_cmd_hprot     (mem_cmd_hprot),
        .mem_wdata_valid   (mem_wdata_valid),
        .mem_wdata_ready   (mem_wdata_ready),
        .mem_wdata         (mem_wdata),
        .mem_wdata_last    (mem_wdata_last),
        .mem_rdata_valid   (mem_rdata_valid),
        .mem_rdata_ready   (mem_rdata_ready),
        .mem_rdata         (mem_rdata),
        .mem_rdata_last    (mem_rdata_last),
        .proto_err         (proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the line the LLC should see and the sticky error flag.
    line_t m_line;
    logic  m_err;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic random_req(output llc_mem_req_t r);
        r.hwrite = 1'($urandom);
        r.hprot  = 2'($urandom);
        r.addr   = 27'($urandom);
        for (int w = 0; w < WORDS_PER_LINE; w++) r.line[w] = {$urandom, $urandom};
    endtask

    // Present the request, then scramble the input port so any later use of it
    // by the DUT shows up as a data error. Returns the cycle of acceptance.
    task automatic issue_req(input logic hwrite, input line_addr_t addr, input hprot_t hprot,
                             input line_t line, output int c_acc);
        llc_mem_req_t garbage;
        check("req_ready_idle", 256'(llc_mem_req_ready), 256'(1));
        llc_mem_req_valid    = 1'b1;
        llc_mem_req_i.hwrite = hwrite;
        llc_mem_req_i.hprot  = hprot;
        llc_mem_req_i.addr   = addr;
        llc_mem_req_i.line   = line;
        @(negedge clk);
        c_acc = cyc;
        llc_mem_req_valid = 1'b0;
        random_req(garbage);
        llc_mem_req_i = garbage;
    endtask

    // Command phase, with optional stall; stray read beats are offered meanwhile.
    task automatic cmd_phase(input logic hwrite, input line_addr_t addr, input hprot_t hprot,
                             input int cmd_stall);
        check("cmd_valid",     256'(mem_cmd_valid), 256'(1));
        check("cmd_write",     256'(mem_cmd_write), 256'(hwrite));
        check("cmd_addr",      256'(mem_cmd_addr),  256'(64'(addr) * 64'(1 << OFFSET_BITS)));
        check("cmd_hprot",     256'(mem_cmd_hprot), 256'(hprot));
        check("req_ready_busy", 256'(llc_mem_req_ready), 256'(0));
        for (int s = 0; s < cmd_stall; s++) begin
            mem_cmd_ready   = 1'b0;
            mem_rdata_valid = 1'b1;
            mem_rdata       = {$urandom, $urandom};
            mem_rdata_last  = 1'($urandom);
            @(negedge clk);
        end
        mem_cmd_ready   = 1'b1;
        mem_rdata_valid = 1'($urandom);
        mem_rdata       = {$urandom, $urandom};
        @(negedge clk);
        mem_cmd_ready   = 1'b0;
        mem_rdata_valid = 1'b0;
        mem_rdata_last  = 1'b0;
    endtask

    // last_beat: beat index carrying mem_rdata_last (WORDS_PER_LINE = never).
    // base != 0 selects data base+i, else random data.
    task automatic do_read(input line_addr_t addr, input hprot_t hprot, input int last_beat,
                           input int cmd_stall, input int gap_max, input int rsp_stall,
                           input word_t base, output int lat);
        int    c_acc, g_tot, nb;
        bit    done;
        word_t d;
        line_t junk;
        for (int w = 0; w < WORDS_PER_LINE; w++) junk[w] = {$urandom, $urandom};
        issue_req(1'b0, addr, hprot, junk, c_acc);
        cmd_phase(1'b0, addr, hprot, cmd_stall);
        g_tot = 0;
        nb    = 0;
        done  = 1'b0;
        for (int i = 0; i < WORDS_PER_LINE && !done; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) @(negedge clk);
            g_tot += g;
            check("rdata_ready", 256'(mem_rdata_ready), 256'(1));
            d = (base != '0) ? base + word_t'(i) : {$urandom, $urandom};
            mem_rdata_valid = 1'b1;
            mem_rdata       = d;
            mem_rdata_last  = (i == last_beat);
            m_line[i] = d;
            if ((i == last_beat) != (i == WORDS_PER_LINE - 1)) m_err = 1'b1;
            if (i == last_beat || i == WORDS_PER_LINE - 1) done = 1'b1;
            nb++;
            @(negedge clk);
            mem_rdata_valid = 1'b0;
            mem_rdata_last  = 1'b0;
        end
        lat = cyc - c_acc;
        check("rd_latency",   256'(lat), 256'(1 + cmd_stall + g_tot + nb));
        check("rsp_valid",    256'(llc_mem_rsp_valid), 256'(1));
        check("rsp_line",     llc_mem_rsp.line, m_line);
        check("proto_err",    256'(proto_err), 256'(m_err));
        for (int s = 0; s < rsp_stall; s++) begin
            llc_mem_rsp_ready = 1'b0;
            @(negedge clk);
            check("rsp_hold_valid", 256'(llc_mem_rsp_valid), 256'(1));
            check("rsp_hold_line",  llc_mem_rsp.line, m_line);
            check("rsp_hold_req",   256'(llc_mem_req_ready), 256'(0));
        end
        llc_mem_rsp_ready = 1'b1;
        @(negedge clk);
        llc_mem_rsp_ready = 1'b0;
        check("rsp_done_valid", 256'(llc_mem_rsp_valid), 256'(0));
        check("rsp_done_idle",  256'(llc_mem_req_ready), 256'(1));
    endtask

    // mode: 0 ready always high, 1 ready toggles (low first), 2 random.
    // abort_at: beat index at which reset is pulsed (>= WORDS_PER_LINE = never).
    task automatic do_write(input line_addr_t addr, input hprot_t hprot, input line_t line,
                            input int mode, input int cmd_stall, input int abort_at,
                            output int occ);
        int c_acc, k, cycles;
        bit rdy;
        occ = 0;
        issue_req(1'b1, addr, hprot, line, c_acc);
        cmd_phase(1'b1, addr, hprot, cmd_stall);
        k      = 0;
        cycles = 0;
        while (k < WORDS_PER_LINE && cycles < 64) begin
            check("wdata_valid", 256'(mem_wdata_valid), 256'(1));
            check("wdata",       256'(mem_wdata), 256'(line[k]));
            check("wdata_last",  256'(mem_wdata_last), 256'(k == WORDS_PER_LINE - 1));
            check("wr_no_rsp",   256'(llc_mem_rsp_valid), 256'(0));
            if (k == abort_at) begin
                rst             = 1'b0;
                mem_wdata_ready = 1'b1;
                @(negedge clk);
                rst             = 1'b1;
                mem_wdata_ready = 1'b0;
                m_line = '0;
                m_err  = 1'b0;
                check("abort_req_ready", 256'(llc_mem_req_ready), 256'(1));
                check("abort_cmd_valid", 256'(mem_cmd_valid),     256'(0));
                check("abort_wd_valid",  256'(mem_wdata_valid),   256'(0));
                check("abort_rd_ready",  256'(mem_rdata_ready),   256'(0));
                check("abort_rsp_valid", 256'(llc_mem_rsp_valid), 256'(0));
                check("abort_proto_err", 256'(proto_err),         256'(m_err));
                check("abort_rsp_line",  llc_mem_rsp.line,        m_line);
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cycles % 2) == 1;
                default: rdy = 1'($urandom);
            endcase
            mem_wdata_ready = rdy;
            if (rdy) k++;
            cycles++;
            @(negedge clk);
        end
        mem_wdata_ready = 1'b0;
        check("wr_beats_done",  256'(k), 256'(WORDS_PER_LINE));
        check("wr_end_wvalid",  256'(mem_wdata_valid), 256'(0));
        check("wr_end_rsp",     256'(llc_mem_rsp_valid), 256'(0));
        check("wr_end_idle",    256'(llc_mem_req_ready), 256'(1));
        occ = cyc - c_acc + 1;
        check("wr_occupancy",   256'(occ), 256'(2 + cmd_stall + cycles));
    endtask

    initial begin
        int    lat, occ, r, lb;
        line_t wl;

        rst               = 1'b0;
        llc_mem_req_valid = 1'b0;
        llc_mem_req_i     = '0;
        llc_mem_rsp_ready = 1'b0;
        mem_cmd_ready     = 1'b0;
        mem_wdata_ready   = 1'b0;
        mem_rdata_valid   = 1'b0;
        mem_rdata         = '0;
        mem_rdata_last    = 1'b0;
        m_line            = '0;
        m_err             = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 256'(llc_mem_req_ready), 256'(1));
        check("rst_cmd_valid", 256'(mem_cmd_valid),     256'(0));
        check("rst_wd_valid",  256'(mem_wdata_valid),   256'(0));
        check("rst_rd_ready",  256'(mem_rdata_ready),   256'(0));
        check("rst_rsp_valid", 256'(llc_mem_rsp_valid), 256'(0));
        check("rst_proto_err", 256'(proto_err),         256'(0));
        check("rst_rsp_line",  llc_mem_rsp.line,        256'(0));
        rst = 1'b1;
        @(negedge clk);

        // 1: plain read, beats A0..A3, last on beat 3.
        do_read(27'h10, 2'b11, 3, 0, 0, 0, 64'hA0, lat);
        check("t1_line", llc_mem_rsp.line, {64'hA3, 64'hA2, 64'hA1, 64'hA0});

        // 2: write {4,3,2,1} with toggling beat ready.
        wl = {64'd4, 64'd3, 64'd2, 64'd1};
        do_write(27'($urandom), 2'($urandom), wl, 1, 0, WORDS_PER_LINE, occ);

        // 3: read with response back-pressure for 5 cycles.
        do_read(27'($urandom), 2'($urandom), 3, 1, 1, 5, '0, lat);

        // 4: early last on beat 1; upper slots keep the previous line.
        do_read(27'($urandom), 2'($urandom), 1, 0, 1, 1, '0, lat);
        check("t4_proto_err", 256'(proto_err), 256'(1));

        // 5: reset during the third write beat, then a normal read.
        for (int w = 0; w < WORDS_PER_LINE; w++) wl[w] = {$urandom, $urandom};
        do_write(27'($urandom), 2'($urandom), wl, 0, 0, 2, occ);
        do_read(27'($urandom), 2'($urandom), 3, 0, 0, 0, '0, lat);
        check("t5_proto_err", 256'(proto_err), 256'(0));

        // 6: back-to-back read then write, no stalls: minimum occupancy.
        do_read(27'($urandom), 2'($urandom), 3, 0, 0, 0, '0, lat);
        check("t6_read_latency", 256'(lat), 256'(1 + WORDS_PER_LINE));
        for (int w = 0; w < WORDS_PER_LINE; w++) wl[w] = {$urandom, $urandom};
        do_write(27'($urandom), 2'($urandom), wl, 0, 0, WORDS_PER_LINE, occ);
        check("t6_write_occ", 256'(occ), 256'(2 + WORDS_PER_LINE));

        // Randomized mix of reads (normal, early last, missing last) and writes.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(1, 0) == 0) begin
                r = int'($urandom_range(7, 0));
                if (r < 6)       lb = WORDS_PER_LINE - 1;
                else if (r == 6) lb = int'($urandom_range(WORDS_PER_LINE - 2, 0));
                else             lb = WORDS_PER_LINE;
                do_read(27'($urandom), 2'($urandom), lb, int'($urandom_range(2, 0)), 2,
                        int'($urandom_range(3, 0)), '0, lat);
            end else begin
                for (int w = 0; w < WORDS_PER_LINE; w++) wl[w] = {$urandom, $urandom};
                do_write(27'($urandom), 2'($urandom), wl, 2, int'($urandom_range(2, 0)),
                         WORDS_PER_LINE, occ);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
